// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing, instruction type codes and entry layout.
package rob_pkg;
    localparam int ROB_WIDTH = 4;
    localparam int ROB_SIZE  = 1 << ROB_WIDTH;

    typedef logic [ROB_WIDTH-1:0] rob_id_t;
    typedef logic [ROB_WIDTH:0]   rob_cnt_t;

    typedef enum logic [1:0] {
        TYPE_REG = 2'd0,
        TYPE_BR  = 2'd1,
        TYPE_ST  = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred_taken;
        logic        taken;
        logic [31:0] val;
    } rob_entry_t;
endpackage

// File: rtl/rob_search_port.sv
// Operand search for one port: stored entry state, bypassed by a same-cycle writeback.
// Purely combinational; the ALU bus wins when both buses name the searched entry.
module rob_search_port
    import rob_pkg::*;
(
    input  rob_id_t     search_id_i,
    input  logic        entry_ready_i,
    input  logic [31:0] entry_val_i,
    input  logic        alu_wb_vld_i,
    input  rob_id_t     alu_wb_id_i,
    input  logic [31:0] alu_wb_dat_i,
    input  logic        lsb_wb_vld_i,
    input  rob_id_t     lsb_wb_id_i,
    input  logic [31:0] lsb_wb_dat_i,
    output logic        search_ready_o,
    output logic [31:0] search_val_o
);
    always_comb begin
        search_ready_o = entry_ready_i;
        search_val_o   = entry_val_i;
        if (lsb_wb_vld_i && lsb_wb_id_i == search_id_i) begin
            search_ready_o = 1'b1;
            search_val_o   = lsb_wb_dat_i;
        end
        if (alu_wb_vld_i && alu_wb_id_i == search_id_i) begin
            search_ready_o = 1'b1;
            search_val_o   = alu_wb_dat_i;
        end
    end
endmodule

// File: rtl/rob.sv
// In-order reorder buffer: allocate at tail, complete from ALU/LSB buses, retire one per cycle at head.
// Commit/clear outputs are registered one cycle after retirement; rdy_in low freezes all state.
module rob
    import rob_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        issue_valid,
    input  logic [1:0]  issue_type,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_pc,
    input  logic        issue_pred_taken,
    output rob_id_t     issue_rob_id,
    output logic        rob_full,
    input  logic        alu_wb_valid,
    input  rob_id_t     alu_wb_rob_id,
    input  logic [31:0] alu_wb_val,
    input  logic        alu_wb_taken,
    input  logic        lsb_wb_valid,
    input  rob_id_t     lsb_wb_rob_id,
    input  logic [31:0] lsb_wb_val,
    input  rob_id_t     search_rob_id_1,
    output logic        search_ready_1,
    output logic [31:0] search_val_1,
    input  rob_id_t     search_rob_id_2,
    output logic        search_ready_2,
    output logic [31:0] search_val_2,
    output logic        commit_ready,
    output logic [4:0]  commit_reg_id,
    output logic [31:0] commit_val,
    output rob_id_t     commit_rob_id,
    output logic        store_commit,
    output logic        clear,
    output logic [31:0] clear_pc
);
    localparam rob_cnt_t FULL_LVL = rob_cnt_t'(ROB_SIZE - 1);

    rob_entry_t  ent_q [ROB_SIZE];
    rob_entry_t  ent_d [ROB_SIZE];
    rob_id_t     head_q, head_d, tail_q, tail_d;
    rob_cnt_t    count_q, count_d;
    logic        commit_ready_q, commit_ready_d;
    logic [4:0]  commit_reg_id_q, commit_reg_id_d;
    logic [31:0] commit_val_q, commit_val_d;
    rob_id_t     commit_rob_id_q, commit_rob_id_d;
    logic        store_commit_q, store_commit_d;
    logic        clear_q, clear_d;
    logic [31:0] clear_pc_q, clear_pc_d;

    rob_entry_t  head_ent;
    logic        do_issue, do_commit, mispredict;

    assign head_ent   = ent_q[head_q];
    assign rob_full   = count_q >= FULL_LVL;
    // The cycle that presents clear is already post-flush; it must not accept new work.
    assign do_issue   = issue_valid && !clear_q && !rob_full;
    assign do_commit  = (count_q != '0) && head_ent.ready && !clear_q;
    assign mispredict = do_commit && (head_ent.typ == TYPE_BR)
                        && (head_ent.taken != head_ent.pred_taken);

    always_comb begin
        ent_d           = ent_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_ready_d  = 1'b0;
        commit_reg_id_d = '0;
        commit_val_d    = '0;
        commit_rob_id_d = '0;
        store_commit_d  = 1'b0;
        clear_d         = 1'b0;
        clear_pc_d      = '0;

        if (!clear_q) begin
            if (alu_wb_valid && ent_q[alu_wb_rob_id].busy) begin
                ent_d[alu_wb_rob_id].ready = 1'b1;
                ent_d[alu_wb_rob_id].val   = alu_wb_val;
                if (ent_q[alu_wb_rob_id].typ == TYPE_BR)
                    ent_d[alu_wb_rob_id].taken = alu_wb_taken;
            end
            if (lsb_wb_valid && ent_q[lsb_wb_rob_id].busy) begin
                ent_d[lsb_wb_rob_id].ready = 1'b1;
                ent_d[lsb_wb_rob_id].val   = lsb_wb_val;
            end
        end

        if (do_commit) begin
            ent_d[head_q].busy  = 1'b0;
            ent_d[head_q].ready = 1'b0;
            head_d              = head_q + rob_id_t'(1);
            commit_ready_d      = 1'b1;
            commit_reg_id_d     = (head_ent.typ == TYPE_REG) ? head_ent.rd : 5'd0;
            commit_val_d        = head_ent.val;
            commit_rob_id_d     = head_q;
            store_commit_d      = (head_ent.typ == TYPE_ST);
        end

        if (do_issue) begin
            ent_d[tail_q].busy       = 1'b1;
            ent_d[tail_q].ready      = 1'b0;
            ent_d[tail_q].typ        = rob_type_e'(issue_type);
            ent_d[tail_q].rd         = issue_rd;
            ent_d[tail_q].pc         = issue_pc;
            ent_d[tail_q].pred_taken = issue_pred_taken;
            ent_d[tail_q].taken      = 1'b0;
            tail_d                   = tail_q + rob_id_t'(1);
        end

        case ({do_issue, do_commit})
            2'b10:   count_d = count_q + rob_cnt_t'(1);
            2'b01:   count_d = count_q - rob_cnt_t'(1);
            default: count_d = count_q;
        endcase

        // Flush on the retiring edge so the clear cycle already sees an empty buffer.
        if (mispredict) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_d[i].busy  = 1'b0;
                ent_d[i].ready = 1'b0;
            end
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            clear_d    = 1'b1;
            clear_pc_d = head_ent.taken ? head_ent.val : head_ent.pc + 32'd4;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_ready_q  <= 1'b0;
            commit_reg_id_q <= '0;
            commit_val_q    <= '0;
            commit_rob_id_q <= '0;
            store_commit_q  <= 1'b0;
            clear_q         <= 1'b0;
            clear_pc_q      <= '0;
        end else if (rdy_in) begin
            ent_q           <= ent_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_ready_q  <= commit_ready_d;
            commit_reg_id_q <= commit_reg_id_d;
            commit_val_q    <= commit_val_d;
            commit_rob_id_q <= commit_rob_id_d;
            store_commit_q  <= store_commit_d;
            clear_q         <= clear_d;
            clear_pc_q      <= clear_pc_d;
        end
    end

    assign issue_rob_id  = tail_q;
    assign commit_ready  = commit_ready_q;
    assign commit_reg_id = commit_reg_id_q;
    assign commit_val    = commit_val_q;
    assign commit_rob_id = commit_rob_id_q;
    assign store_commit  = store_commit_q;
    assign clear         = clear_q;
    assign clear_pc      = clear_pc_q;

    rob_search_port u_search_1 (
        .search_id_i    (search_rob_id_1),
        .entry_ready_i  (ent_q[search_rob_id_1].ready),
        .entry_val_i    (ent_q[search_rob_id_1].val),
        .alu_wb_vld_i   (alu_wb_valid),
        .alu_wb_id_i    (alu_wb_rob_id),
        .alu_wb_dat_i   (alu_wb_val),
        .lsb_wb_vld_i   (lsb_wb_valid),
        .lsb_wb_id_i    (lsb_wb_rob_id),
        .lsb_wb_dat_i   (lsb_wb_val),
        .search_ready_o (search_ready_1),
        .search_val_o   (search_val_1)
    );

    rob_search_port u_search_2 (
        .search_id_i    (search_rob_id_2),
        .entry_ready_i  (ent_q[search_rob_id_2].ready),
        .entry_val_i    (ent_q[search_rob_id_2].val),
        .alu_wb_vld_i   (alu_wb_valid),
        .alu_wb_id_i    (alu_wb_rob_id),
        .alu_wb_dat_i   (alu_wb_val),
        .lsb_wb_vld_i   (lsb_wb_valid),
        .lsb_wb_id_i    (lsb_wb_rob_id),
        .lsb_wb_dat_i   (lsb_wb_val),
        .search_ready_o (search_ready_2),
        .search_val_o   (search_val_2)
    );
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer that sits directly upstream of the register file.
- Allocates an in-order entry per decoded instruction and collects results from the ALU and load/store writeback buses.
- Retires entries in program order, driving the regfile commit port (reg id, value, rob id).
- Answers operand searches for registers still tagged in the regfile, and raises the global clear on a branch mispredict.

Parameters:
ROB_WIDTH, 4, entry index width; ROB_SIZE = 2**ROB_WIDTH entries

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  pause when low: all state holds
issue_valid  in  1  decoder allocates an entry this cycle
issue_type  in  2  0=reg-write, 1=branch, 2=store
issue_rd  in  5  destination register (ignored unless type 0)
issue_pc  in  32  instruction pc
issue_pred_taken  in  1  predictor decision (branch only)
issue_rob_id  out  ROB_WIDTH  tail index; id the next issue receives
rob_full  out  1  count >= ROB_SIZE-1
alu_wb_valid  in  1  ALU result valid
alu_wb_rob_id  in  ROB_WIDTH  target entry
alu_wb_val  in  32  result; for branch: resolved target
alu_wb_taken  in  1  branch outcome
lsb_wb_valid  in  1  LSB result/store-ready valid
lsb_wb_rob_id  in  ROB_WIDTH  target entry
lsb_wb_val  in  32  load data
search_rob_id_1  in  ROB_WIDTH  operand-1 search
search_ready_1  out  1  entry 1 result available
search_val_1  out  32  entry 1 value
search_rob_id_2  in  ROB_WIDTH  operand-2 search
search_ready_2  out  1  entry 2 result available
search_val_2  out  32  entry 2 value
commit_ready  out  1  registered commit pulse to regfile
commit_reg_id  out  5  committed rd; 0 for branch/store
commit_val  out  32  committed value
commit_rob_id  out  ROB_WIDTH  committed entry index
store_commit  out  1  registered pulse: head store may write memory
clear  out  1  registered one-cycle flush
clear_pc  out  32  refetch pc, valid with clear

Behaviour:
- Reset (asynchronous, any time): head=tail=count=0, all entries busy=0 ready=0. Outputs commit_ready, store_commit, clear = 0; commit_reg_id, commit_val, commit_rob_id, clear_pc = 0.
- rdy_in low: no state change; registered outputs hold.
- Issue (issue_valid and !clear): entry[tail] gets busy=1, ready=0, type, rd, pc, pred_taken. Then tail+1 mod ROB_SIZE.
  - Decoder must not issue while rob_full. If it does, the issue is ignored.
  - The one-entry slack covers the one-cycle lag of the registered full.
- Writeback:
  - Either bus sets ready=1 and val on the named busy entry. Branches also record taken.
  - Both buses in one cycle target distinct ids; both apply.
  - Writeback to a non-busy entry is ignored.
- Search (combinational): ready = entry ready, or a writeback to that id this cycle. val is the entry value, or the bus value when bypassed. ALU bus has priority over LSB if both match.
- Commit, at most one per cycle: when count!=0 and entry[head] ready, head and count advance. Next cycle:
  - commit_ready=1, commit_rob_id=head, commit_val=val.
  - commit_reg_id = rd for type 0, 0 otherwise.
  - store_commit=1 for type 2.
  - Outputs fall to 0 the following cycle unless another commit occurs.
- Mispredict: a committing branch with taken != pred_taken produces, next cycle:
  - clear=1.
  - clear_pc = taken ? val : pc+4.
  - ROB flushed: head=tail=count=0, all busy=0.
  - Issue and writeback in the clear cycle are ignored.
  - A correctly predicted branch just retires, with no clear.
- Simultaneous issue and commit: count unchanged, tail and head both advance.
- Wrap-around: indices modulo ROB_SIZE. Full and empty are distinguished by count, never by head==tail.
- Width rule: pc+4 wraps modulo 2^32.

Decomposition:
- Shared defines file: ROB_WIDTH/ROB_SIZE, entry type codes (TYPE_REG, TYPE_BR, TYPE_ST).
- Entry storage uses plain arrays, with no sub-module.
- Search bypass logic is duplicated per port via one small combinational sub-module, rob_search_port.

Test Plan:
- Reset mid-run with 5 entries live -> count=0, commit_ready=0, issue_rob_id=0 immediately, no clock needed.
- Issue rd=5 (id 0), ALU writeback id 0 val 0x1234 -> next cycle commit_ready=1, reg 5, val 0x1234, rob_id 0.
- Issue ids 0,1; writeback id 1 first, then id 0 -> commits emitted in order id 0 then id 1 on consecutive cycles.
- Fill 15 entries (ROB_WIDTH=4) -> rob_full=1. A further issue is ignored. After a commit, rob_full=0.
- Branch at pc 0x100, pred_taken=0, ALU writes taken=1 target 0x200 -> clear=1, clear_pc=0x200. Next cycle count=0, issue_rob_id=0.
- Search id 3 while ALU writes id 3 val 7 the same cycle -> search_ready=1, search_val=7 combinationally.
